mpu_load_ctrl: RTL
==================

Name: mpu_load_ctrl

Overview:
- Load-side front end of the MPU. Accepts a matrix element stream from memory or the testbench under an en/ack handshake.
- Validates the declared matrix dimensions.
- Issues one registered write per element, in row-major order, to the matrix register file at the selected register address.
- Sits directly downstream of the MPU load interface and directly upstream of the matrix register file.

Parameters:
- FP, 32, element width in bits (32 or 64 float).
- M, 4, maximum matrix rows.
- N, 4, maximum matrix columns.
- MBITS, $clog2(M), row index width minus 1; size ports are MBITS+1 bits.
- NBITS, $clog2(N), column index width minus 1; size ports are NBITS+1 bits.
- MATRIX_REG_SIZE, 2, matrix register address width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  load request; held high for the entire load.
- load_addr  in  MATRIX_REG_SIZE  destination matrix register.
- matrix_m_size  in  MBITS+1  row count of incoming matrix.
- matrix_n_size  in  NBITS+1  column count of incoming matrix.
- element  in  FP  element data.
- valid  in  1  element qualifier; element is sampled only when valid & ack.
- ack  out  1  high while the block accepts elements.
- error  out  1  size violation or aborted load.
- reg_write  out  1  one-cycle register-file write strobe.
- reg_load_addr  out  MATRIX_REG_SIZE  latched destination register.
- element_out  out  FP  write data.
- m  out  MBITS+1  write row index.
- n  out  NBITS+1  write column index.
- m_size  out  MBITS+1  latched row count, valid from ack until the next load.
- n_size  out  NBITS+1  latched column count, valid from ack until the next load.
- load_complete  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output is 0 immediately. This applies mid-load too: no further writes, and partial contents in the register file are not undone.
- States: IDLE, CHECK, LOAD, DONE, ERR.
- IDLE: when en=1 at an edge, latch load_addr, matrix_m_size and matrix_n_size, then go to CHECK.
- CHECK (1 cycle):
  - If 1<=m_size<=M and 1<=n_size<=N, go to LOAD and assert ack. Ack is therefore high 2 edges after the edge where en was sampled high.
  - Otherwise go to ERR.
- LOAD, ack=1, internal counters r and c start at 0:
  - Each edge with valid=1 registers element_out=element, m=r, n=c, reg_load_addr=latched addr, and pulses reg_write=1 for the following cycle.
  - Counter order is row-major: c++; when c==n_size-1, c=0 and r++.
  - valid=0 means no write and no counter change.
  - The edge that accepts element number m_size*n_size-1 clears ack (ack low from the next cycle) and moves to DONE.
  - valid while ack=0 is ignored in every state.
- DONE: load_complete=1 for exactly one cycle, coinciding with the cycle after the final reg_write cycle. Then stay in DONE with outputs low until en=0, then go to IDLE.
- Abort: en=0 at any edge in CHECK or LOAD drops ack, issues no further writes, and goes to ERR.
- ERR: error=1, ack=0. Stay until en=0 is sampled, then clear error and go to IDLE. An abort detected while en is already 0 therefore shows error for 1 cycle.
- Back-to-back loads:
  - A new load needs en low for at least one edge.
  - en held high after DONE or ERR never restarts a load.
- Throughput: 1 element per cycle when valid is held high.
- Latency: 1 cycle from accepted element to reg_write.
- Arithmetic: element data is passed unmodified. Counters never exceed the latched size minus 1, so no wrap beyond the matrix occurs.

Test Plan:
- Reset, then en=1, addr=2, size 2x2, valid continuous, elements 1.0, 2.0, 3.0, 4.0 (32'h3F800000…) -> ack high 2 cycles after en; 4 reg_write pulses with (m,n)=(0,0),(0,1),(1,0),(1,1); reg_load_addr=2; ack low after the 4th accept; load_complete one cycle later.
- Size 3x1 with valid toggling 1,0,1,0,1 -> exactly 3 writes at (0,0),(1,0),(2,0); no writes on valid=0 cycles.
- Size 0x2, then 5x1 with M=4 -> ack never rises; error high until en dropped; reg_write never pulses.
- 4x4 load with en dropped after 6 accepted elements -> 6 writes only; ack falls; error pulses 1 cycle; a following 1x1 load succeeds.
- rst asserted low mid-load, asynchronously between edges -> ack, reg_write and error are 0 immediately; after release, a fresh 2x3 load completes normally with 6 writes.
- en held high after load_complete -> no second ack; after en low for 1 cycle then high, a new load starts normally.

Source files
------------

// File: rtl/mpu_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// mpu_load_ctrl_if
// Bundles the load-side handshake (en/valid/ack, sizes, element data) and the
// register-file write port of the MPU load controller.
//   master : load source side (drives request, sizes and element stream,
//            observes ack/error and the write port)
//   slave  : the load controller itself
// -----------------------------------------------------------------------------
interface mpu_load_ctrl_if #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MATRIX_REG_SIZE = 2
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);

  // load request side
  logic                       en;
  logic [MATRIX_REG_SIZE-1:0] load_addr;
  logic [MBITS:0]             matrix_m_size;
  logic [NBITS:0]             matrix_n_size;
  logic [FP-1:0]              element;
  logic                       valid;
  logic                       ack;
  logic                       error;

  // register-file write side
  logic                       reg_write;
  logic [MATRIX_REG_SIZE-1:0] reg_load_addr;
  logic [FP-1:0]              element_out;
  logic [MBITS:0]             m;
  logic [NBITS:0]             n;
  logic [MBITS:0]             m_size;
  logic [NBITS:0]             n_size;
  logic                       load_complete;

  modport master (
    output en, load_addr, matrix_m_size, matrix_n_size, element, valid,
    input  ack, error, reg_write, reg_load_addr, element_out, m, n,
           m_size, n_size, load_complete
  );

  modport slave (
    input  en, load_addr, matrix_m_size, matrix_n_size, element, valid,
    output ack, error, reg_write, reg_load_addr, element_out, m, n,
           m_size, n_size, load_complete
  );
endinterface

// File: rtl/mpu_load_ctrl.sv
// -----------------------------------------------------------------------------
// mpu_load_ctrl
// Load-side front end of the MPU. Latches the destination register and matrix
// dimensions, validates the dimensions, then accepts one element per cycle
// (valid & ack) and issues a registered row-major write to the matrix register
// file. Dropping en during CHECK or LOAD aborts the load into ERR.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous active-low reset, clears state and every output
//   bus  : mpu_load_ctrl_if.slave (request/element stream in, write port out)
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module mpu_load_ctrl #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MATRIX_REG_SIZE = 2
) (
  input  logic           clk,
  input  logic           rst,
  mpu_load_ctrl_if.slave bus
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);

  localparam logic [MBITS:0] M_MAX  = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX  = (NBITS+1)'(N);
  localparam logic [MBITS:0] M_ONE  = (MBITS+1)'(1);
  localparam logic [NBITS:0] N_ONE  = (NBITS+1)'(1);
  localparam logic [MBITS:0] M_ZERO = (MBITS+1)'(0);
  localparam logic [NBITS:0] N_ZERO = (NBITS+1)'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_LOAD  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [MBITS:0]             r_q, r_d;
  logic [NBITS:0]             c_q, c_d;
  logic [MATRIX_REG_SIZE-1:0] addr_q, addr_d;
  logic [MBITS:0]             m_size_q, m_size_d;
  logic [NBITS:0]             n_size_q, n_size_d;
  logic                       ack_q, ack_d;
  logic                       error_q, error_d;
  logic                       reg_write_q, reg_write_d;
  logic                       load_complete_q, load_complete_d;
  logic [MATRIX_REG_SIZE-1:0] reg_load_addr_q, reg_load_addr_d;
  logic [FP-1:0]              element_q, element_d;
  logic [MBITS:0]             m_q, m_d;
  logic [NBITS:0]             n_q, n_d;

  logic size_ok_s;
  logic last_s;

  // Dimension check and final-element detect on the latched sizes.
  always_comb begin
    size_ok_s = (m_size_q != M_ZERO) && (m_size_q <= M_MAX) &&
                (n_size_q != N_ZERO) && (n_size_q <= N_MAX);
    last_s    = (r_q == (m_size_q - M_ONE)) && (c_q == (n_size_q - N_ONE));
  end

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d         = state_q;
    r_d             = r_q;
    c_d             = c_q;
    addr_d          = addr_q;
    m_size_d        = m_size_q;
    n_size_d        = n_size_q;
    ack_d           = 1'b0;
    error_d         = 1'b0;
    reg_write_d     = 1'b0;
    load_complete_d = 1'b0;
    reg_load_addr_d = reg_load_addr_q;
    element_d       = element_q;
    m_d             = m_q;
    n_d             = n_q;

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          addr_d   = bus.load_addr;
          m_size_d = bus.matrix_m_size;
          n_size_d = bus.matrix_n_size;
          r_d      = M_ZERO;
          c_d      = N_ZERO;
          state_d  = S_CHECK;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_CHECK: begin
        if (!bus.en || !size_ok_s) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          ack_d   = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!bus.en) begin
          // abort: ack drops with no further writes
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (bus.valid && ack_q) begin
          reg_write_d     = 1'b1;
          element_d       = bus.element;
          m_d             = r_q;
          n_d             = c_q;
          reg_load_addr_d = addr_q;
          if (last_s) begin
            ack_d   = 1'b0;
            state_d = S_DONE;
          end else if (c_q == (n_size_q - N_ONE)) begin
            ack_d   = 1'b1;
            c_d     = N_ZERO;
            r_d     = r_q + M_ONE;
          end else begin
            ack_d   = 1'b1;
            c_d     = c_q + N_ONE;
          end
        end else begin
          ack_d = 1'b1;
        end
      end

      S_DONE: begin
        // reg_write_q is high only in the first DONE cycle (final write),
        // so load_complete lands in the cycle right after it.
        load_complete_d = reg_write_q;
        if (!bus.en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      S_ERR: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else begin
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      r_q             <= M_ZERO;
      c_q             <= N_ZERO;
      addr_q          <= {MATRIX_REG_SIZE{1'b0}};
      m_size_q        <= M_ZERO;
      n_size_q        <= N_ZERO;
      ack_q           <= 1'b0;
      error_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      load_complete_q <= 1'b0;
      reg_load_addr_q <= {MATRIX_REG_SIZE{1'b0}};
      element_q       <= {FP{1'b0}};
      m_q             <= M_ZERO;
      n_q             <= N_ZERO;
    end else begin
      state_q         <= state_d;
      r_q             <= r_d;
      c_q             <= c_d;
      addr_q          <= addr_d;
      m_size_q        <= m_size_d;
      n_size_q        <= n_size_d;
      ack_q           <= ack_d;
      error_q         <= error_d;
      reg_write_q     <= reg_write_d;
      load_complete_q <= load_complete_d;
      reg_load_addr_q <= reg_load_addr_d;
      element_q       <= element_d;
      m_q             <= m_d;
      n_q             <= n_d;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.error         = error_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.reg_load_addr = reg_load_addr_q;
  assign bus.element_out   = element_q;
  assign bus.m             = m_q;
  assign bus.n             = n_q;
  assign bus.m_size        = m_size_q;
  assign bus.n_size        = n_size_q;
  assign bus.load_complete = load_complete_q;

endmodule
